ahb_mem_responder: RTL

AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

---
 rtl/ahb_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-Lite slave backed by 2^MEM_AW x 32-bit internal storage.
// Transfers are classified at the address phase. Illegal transfers get the
// two-cycle ERROR response and never touch storage. Writes commit at the end of
// the DATA cycle, using byte lanes chosen from hsize and the byte offset.
// Optional macro AHB_RESP_WAIT_EN: when it is defined, every legal transfer
// spends WAIT_CYCLES cycles in WAIT before its DATA cycle.
module ahb_mem_responder #(
   parameter int MEM_AW      = 10
`ifdef AHB_RESP_WAIT_EN
   , parameter int WAIT_CYCLES = 2
`endif
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [31:0] hwdata,
   input  logic        hready_in,
   output logic [31:0] hrdata,
   output logic        hready_out,
   output logic [1:0]  hresp
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t              r_state, w_next;
   logic [31:0]         r_mem [2**MEM_AW];
   logic [MEM_AW-1:0]   r_widx;
   logic [1:0]          r_off;
   logic [2:0]          r_size;
   logic                r_write;
   logic                w_accept, w_err, w_take;
   logic [3:0]          w_be;
   logic                w_unused;

   // hburst carries no information this slave needs
   assign w_unused = ^hburst;

   assign w_accept = hsel & hready_in & htrans[1];
   assign w_err    = (|haddr[31:MEM_AW+2]) | (hsize > 3'd2) |
                     ((hsize == 3'd2) & (|haddr[1:0])) |
                     ((hsize == 3'd1) & haddr[0]);
   // Only IDLE and DATA sample the address bus; an address phase seen in ERR2 is dropped
   assign w_take   = w_accept & ((r_state == S_IDLE) | (r_state == S_DATA));

`ifdef AHB_RESP_WAIT_EN
   logic [3:0] r_wcnt;

   // Count cycles spent in WAIT; cleared whenever WAIT is left or not entered
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset)                                   r_wcnt <= '0;
      else if (r_state == S_WAIT && w_next == S_WAIT) r_wcnt <= r_wcnt + 4'd1;
      else                                          r_wcnt <= '0;
   end
`endif

   // FSM state register
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Capture address-phase attributes of each accepted transfer
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_widx  <= '0;
         r_off   <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
      end else if (w_take) begin
         r_widx  <= haddr[MEM_AW+1:2];
         r_off   <= haddr[1:0];
         r_size  <= hsize;
         r_write <= hwrite;
      end
   end

   // Next state and bus response
   always_comb begin
      w_next     = r_state;
      hready_out = 1'b1;
      hresp      = 2'b00;
      hrdata     = '0;
      case (r_state)
         S_IDLE, S_DATA: begin
            if (r_state == S_DATA && !r_write) hrdata = r_mem[r_widx];
            if (w_take) begin
               if (w_err) w_next = S_ERR1;
`ifdef AHB_RESP_WAIT_EN
               else       w_next = S_WAIT;
`else
               else       w_next = S_DATA;
`endif
            end else begin
               w_next = S_IDLE;
            end
         end
         S_WAIT: begin
            hready_out = 1'b0;
`ifdef AHB_RESP_WAIT_EN
            if (r_wcnt == 4'(WAIT_CYCLES - 1)) w_next = S_DATA;
`else
            w_next = S_DATA;
`endif
         end
         S_ERR1: begin
            hready_out = 1'b0;
            hresp      = 2'b01;
            w_next     = S_ERR2;
         end
         S_ERR2: begin
            hresp  = 2'b01;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Little-endian lane enables: byte hits lane off, halfword hits off and off+1
   always_comb begin
      case (r_size)
         3'd0:    w_be = 4'b0001 << r_off;
         3'd1:    w_be = 4'b0011 << r_off;
         default: w_be = 4'b1111;
      endcase
   end

   // Storage write at the end of a write's DATA cycle. Storage keeps its contents through reset
   always_ff @(posedge hclk) begin
      if (!hreset && r_state == S_DATA && r_write) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[r_widx][8*b +: 8] <= hwdata[8*b +: 8];
      end
   end

endmodule
